// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding-mode encodings, flag bit
// positions and the canonical quiet-NaN pattern for any format width.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  // Positive sign, all-ones exponent, fraction MSB set; returned in the
  // low 1+exp_w+frac_w bits of a 64-bit word.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int frac_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounding decision and significand increment for one normalised operand.
// The returned significand carries an extra MSB that is set when rounding
// overflows the hidden bit.
module fp_round
  import fp_pkg::*;
#(
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W+3:0] man,
  input  logic              sign,
  input  logic [1:0]        rm,
  output logic [FRAC_W+1:0] sig,
  output logic              inexact
);

  logic lsb;
  logic guard_bit;
  logic round_bit;
  logic sticky_bit;
  logic inc;

  // Decide whether to add one ulp, then form the rounded significand.
  always_comb begin
    lsb        = man[3];
    guard_bit  = man[2];
    round_bit  = man[1];
    sticky_bit = man[0];
    inexact    = guard_bit | round_bit | sticky_bit;
    inc        = 1'b0;
    case (rm)
      RM_RNE:  inc = guard_bit && (round_bit || sticky_bit || lsb);
      RM_RUP:  inc = !sign && inexact;
      RM_RDN:  inc = sign && inexact;
      default: inc = 1'b0;
    endcase
    sig = {1'b0, man[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, inc};
  end

endmodule

// File: rtl/fp_pack_pipe.sv
// Two-stage round-and-pack pipeline. Stage 1 rounds the significand;
// stage 2 applies the rounding carry to the exponent, resolves specials,
// overflow and underflow, and registers the packed result and flags.
module fp_pack_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_nan,
  input  logic                       in_is_inf,
  input  logic                       in_sign_special,
  input  logic                       in_x_zero,
  input  logic                       in_y_zero,
  input  logic                       in_do_sub,
  input  logic                       in_sign,
  input  logic [EXP_W+1:0]           in_exp,
  input  logic [FRAC_W+3:0]          in_man,
  input  logic [1:0]                 in_rm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1+EXP_W+FRAC_W-1:0]  out_result,
  output logic [3:0]                 out_flags
);

  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [W-1:0] QNAN = W'(canonical_nan(EXP_W, FRAC_W));
  localparam logic signed [EXP_W+2:0] EXP_SAT = (EXP_W+3)'((64'd1 << EXP_W) - 64'd1);

  logic s1_valid;
  logic s2_valid;
  logic s2_advance;

  logic              s1_is_nan;
  logic              s1_is_inf;
  logic              s1_sign_special;
  logic              s1_both_zero;
  logic              s1_do_sub;
  logic              s1_sign;
  logic [1:0]        s1_rm;
  logic [EXP_W+1:0]  s1_exp;
  logic              s1_carry;
  logic [FRAC_W-1:0] s1_frac;
  logic              s1_inexact;

  logic [FRAC_W+1:0] rnd_sig;
  logic              rnd_inexact;

  logic signed [EXP_W+2:0] exp_adj;
  logic                    ovf_to_inf;
  logic                    zero_sign;
  logic [W-1:0]            pack_result;
  logic [3:0]              pack_flags;

  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_valid  = s2_valid;

  fp_round #(.FRAC_W(FRAC_W)) u_round (
    .man     (in_man),
    .sign    (in_sign),
    .rm      (in_rm),
    .sig     (rnd_sig),
    .inexact (rnd_inexact)
  );

  // Stage 1 occupancy: refill whenever the stage is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 payload: rounded fraction already renormalised on carry-out.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_is_nan       <= in_is_nan;
      s1_is_inf       <= in_is_inf;
      s1_sign_special <= in_sign_special;
      s1_both_zero    <= in_x_zero && in_y_zero;
      s1_do_sub       <= in_do_sub;
      s1_sign         <= in_sign;
      s1_rm           <= in_rm;
      s1_exp          <= in_exp;
      s1_carry        <= rnd_sig[FRAC_W+1];
      s1_frac         <= rnd_sig[FRAC_W+1] ? rnd_sig[FRAC_W:1] : rnd_sig[FRAC_W-1:0];
      s1_inexact      <= rnd_inexact;
    end
  end

  // Stage 2 packing with priority NaN, infinity, exact zero, then finite.
  always_comb begin
    pack_result = '0;
    pack_flags  = '0;
    exp_adj     = $signed({s1_exp[EXP_W+1], s1_exp}) + $signed({{(EXP_W+2){1'b0}}, s1_carry});
    ovf_to_inf  = (s1_rm == RM_RNE) || ((s1_rm == RM_RUP) && !s1_sign) ||
                  ((s1_rm == RM_RDN) && s1_sign);
    zero_sign   = s1_do_sub ? (s1_rm == RM_RDN) : s1_sign;
    if (s1_is_nan) begin
      pack_result               = QNAN;
      pack_flags[FLAG_INVALID]  = 1'b1;
    end else if (s1_is_inf) begin
      pack_result = {s1_sign_special, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (s1_both_zero) begin
      pack_result = {zero_sign, {(W-1){1'b0}}};
    end else if (exp_adj >= EXP_SAT) begin
      pack_flags[FLAG_OVERFLOW] = 1'b1;
      pack_flags[FLAG_INEXACT]  = 1'b1;
      if (ovf_to_inf) begin
        pack_result = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else begin
        pack_result = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      end
    end else if (exp_adj <= 0) begin
      pack_result                = {s1_sign, {(W-1){1'b0}}};
      pack_flags[FLAG_UNDERFLOW] = 1'b1;
      pack_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      pack_result              = {s1_sign, exp_adj[EXP_W-1:0], s1_frac};
      pack_flags[FLAG_INEXACT] = s1_inexact;
    end
  end

  // Stage 2 output registers, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= pack_result;
        out_flags  <= pack_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_pack_pipe.sv
// Self-checking bench for fp_pack_pipe with the default single-precision
// format. Expected values come from an integer reference model and a FIFO
// scoreboard of accepted operands.
module tb_fp_pack_pipe;

  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        ss;
    logic        xz;
    logic        yz;
    logic        dsub;
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] man;
    logic [1:0]  rm;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_nan;
  logic        in_is_inf;
  logic        in_sign_special;
  logic        in_x_zero;
  logic        in_y_zero;
  logic        in_do_sub;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic stalled_prev = 1'b0;
  logic [31:0] held_result;
  logic [3:0]  held_flags;

  fp_pack_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_is_nan       (in_is_nan),
    .in_is_inf       (in_is_inf),
    .in_sign_special (in_sign_special),
    .in_x_zero       (in_x_zero),
    .in_y_zero       (in_y_zero),
    .in_do_sub       (in_do_sub),
    .in_sign         (in_sign),
    .in_exp          (in_exp),
    .in_man          (in_man),
    .in_rm           (in_rm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_flags       (out_flags)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so a wedged pipeline cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: round with integer arithmetic, then classify.
  function automatic exp_t model(input op_t o);
    exp_t r;
    int   sig;
    int   e;
    logic g, rr, s, any, inc, to_inf;
    r = '0;
    if (o.nan) begin
      r.res = 32'h7FC00000;
      r.flg = 4'b1000;
    end else if (o.inf) begin
      r.res = {o.ss, 8'hFF, 23'h0};
    end else if (o.xz && o.yz) begin
      r.res = {(o.dsub ? (o.rm == 2'd3) : o.sign), 31'h0};
    end else begin
      sig = int'(o.man >> 3);
      g   = o.man[2];
      rr  = o.man[1];
      s   = o.man[0];
      any = g | rr | s;
      case (o.rm)
        2'd0:    inc = g && (rr || s || sig[0]);
        2'd2:    inc = !o.sign && any;
        2'd3:    inc = o.sign && any;
        default: inc = 1'b0;
      endcase
      sig = sig + (inc ? 1 : 0);
      e   = int'($signed(o.exp));
      if (sig >= (1 << 24)) begin
        sig = sig >> 1;
        e   = e + 1;
      end
      to_inf = (o.rm == 2'd0) || (o.rm == 2'd2 && !o.sign) || (o.rm == 2'd3 && o.sign);
      if (e >= 255) begin
        r.flg = 4'b0101;
        r.res = to_inf ? {o.sign, 8'hFF, 23'h0} : {o.sign, 8'hFE, 23'h7FFFFF};
      end else if (e <= 0) begin
        r.flg = 4'b0011;
        r.res = {o.sign, 31'h0};
      end else begin
        r.flg = {3'b000, any};
        r.res = {o.sign, e[7:0], sig[22:0]};
      end
    end
    return r;
  endfunction

  function automatic op_t mk_op(input int e, input logic [26:0] m, input logic [1:0] rm,
                                input logic sign);
    op_t o;
    o      = '0;
    o.exp  = 10'(e);
    o.man  = m;
    o.rm   = rm;
    o.sign = sign;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  sel;
    int  e;
    int  band;
    o      = '0;
    sel    = $urandom_range(0, 19);
    o.nan  = (sel == 0) || (sel == 5);
    o.inf  = (sel == 1) || (sel == 5);
    o.xz   = (sel == 2) || (sel == 3);
    o.yz   = (sel == 2) || (sel == 4);
    o.ss   = 1'($urandom);
    o.dsub = 1'($urandom);
    o.sign = 1'($urandom);
    o.rm   = 2'($urandom);
    band   = $urandom_range(0, 9);
    case (band)
      0:       e = -$urandom_range(0, 20);
      1:       e = $urandom_range(253, 256);
      2:       e = $urandom_range(0, 2);
      default: e = $urandom_range(1, 254);
    endcase
    o.exp = 10'(e);
    o.man = {1'b1, 26'($urandom)};
    if ($urandom_range(0, 3) == 0) o.man[25:3] = '1;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: stability while stalled, ordered delivery on transfer.
  task automatic sampleOutput();
    exp_t e;
    if (stalled_prev) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_result", out_result, held_result);
      checkOutput("stall_flags", out_flags, held_flags);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", out_valid, exp_q.size() > 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("result", out_result, e.res);
        checkOutput("flags", out_flags, e.flg);
      end
    end
    stalled_prev = out_valid && !out_ready;
    held_result  = out_result;
    held_flags   = out_flags;
  endtask

  task automatic applyStimulus(input op_t op, input logic v, input logic ordy, output logic acc);
    int n;
    @(negedge clk);
    in_valid        = v;
    in_is_nan       = op.nan;
    in_is_inf       = op.inf;
    in_sign_special = op.ss;
    in_x_zero       = op.xz;
    in_y_zero       = op.yz;
    in_do_sub       = op.dsub;
    in_sign         = op.sign;
    in_exp          = op.exp;
    in_man          = op.man;
    in_rm           = op.rm;
    out_ready       = ordy;
    #1;
    n = exp_q.size();
    sampleOutput();
    checkOutput("in_ready", in_ready, (n < 2) || ordy);
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(op));
  endtask

  task automatic drain();
    logic acc;
    int   budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      applyStimulus('0, 1'b0, 1'b1, acc);
      budget++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  // One operand into an empty pipeline; result must appear two cycles on.
  task automatic run_directed(input string tag, input op_t op, input logic [31:0] res,
                              input logic [3:0] flg);
    logic acc;
    applyStimulus(op, 1'b1, 1'b1, acc);
    checkOutput({tag, "_accept"}, acc, 1);
    applyStimulus('0, 1'b0, 1'b1, acc);
    checkOutput({tag, "_lat1"}, out_valid, 0);
    applyStimulus('0, 1'b0, 1'b1, acc);
    checkOutput({tag, "_lat2"}, out_valid, 1);
    checkOutput({tag, "_res"}, out_result, res);
    checkOutput({tag, "_flags"}, out_flags, flg);
  endtask

  initial begin
    op_t  cur;
    op_t  bp_ops[4];
    logic acc;
    logic have;
    int   idx;
    int   k;

    rst = 1'b1;
    in_valid = 1'b0; in_is_nan = 1'b0; in_is_inf = 1'b0; in_sign_special = 1'b0;
    in_x_zero = 1'b0; in_y_zero = 1'b0; in_do_sub = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_man = '0; in_rm = '0; out_ready = 1'b0;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_out_flags", out_flags, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] directed cases");
    run_directed("rne_tie", mk_op(127, {1'b1, 23'h000001, 3'b100}, 2'd0, 1'b0),
                 32'h3F800002, 4'b0001);
    run_directed("ovf_rne", mk_op(254, {1'b1, 23'h7FFFFF, 3'b100}, 2'd0, 1'b0),
                 32'h7F800000, 4'b0101);
    run_directed("ovf_rtz", mk_op(254, {1'b1, 23'h7FFFFF, 3'b100}, 2'd1, 1'b0),
                 32'h7F7FFFFF, 4'b0001);
    cur = mk_op(100, 27'h5A5A5A5, 2'd0, 1'b0);
    cur.nan = 1'b1;
    run_directed("nan", cur, 32'h7FC00000, 4'b1000);
    cur = mk_op(3, 27'h7FFFFFF, 2'd2, 1'b0);
    cur.inf = 1'b1;
    cur.ss  = 1'b1;
    run_directed("inf_neg", cur, 32'hFF800000, 4'b0000);
    cur = mk_op(50, 27'h4000007, 2'd3, 1'b0);
    cur.xz = 1'b1; cur.yz = 1'b1; cur.dsub = 1'b1;
    run_directed("zero_rdn", cur, 32'h80000000, 4'b0000);
    cur.rm = 2'd0;
    cur.sign = 1'b1;
    run_directed("zero_rne", cur, 32'h00000000, 4'b0000);
    run_directed("underflow", mk_op(0, {1'b1, 26'($urandom)}, 2'd1, 1'b1),
                 32'h80000000, 4'b0011);

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) bp_ops[i] = mk_op(120 + i, {1'b1, 26'($urandom)}, 2'($urandom), 1'($urandom));
    idx = 0;
    k   = 0;
    while ((idx < 4 || k < 8) && k < 30) begin
      applyStimulus(bp_ops[idx % 4], idx < 4, !(k >= 2 && k <= 4), acc);
      if (acc) idx++;
      k++;
    end
    checkOutput("bp_all_accepted", idx, 4);
    drain();

    $display("[TB] reset with full pipeline");
    applyStimulus(rand_op(), 1'b1, 1'b0, acc);
    applyStimulus(rand_op(), 1'b1, 1'b0, acc);
    applyStimulus('0, 1'b0, 1'b0, acc);
    checkOutput("full_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_result", out_result, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    stalled_prev = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus('0, 1'b0, 1'b1, acc);
      checkOutput("post_rst_idle", out_valid, 0);
    end

    $display("[TB] random traffic");
    have = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!have) begin
        cur  = rand_op();
        have = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(cur, have, $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
